// File: rtl/if_id_queue.sv
// Fetch-to-decode skid queue: buffers fetch words in a small circular FIFO, presents the head to decode
// with valid/ready and stalls fetch when full. Optional same-cycle forwarding when empty: IFID_BYPASS_EN.
module if_id_queue #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [31:0]                  in_pc,
   input  logic [31:0]                  in_instr,
   output logic                         is_stall,
   input  logic                         flush,
   output logic                         id_valid,
   input  logic                         id_ready,
   output logic [31:0]                  id_pc,
   output logic [31:0]                  id_instr,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];

   logic fifo_valid;
   logic bypass;
   logic push;
   logic pop;

   // Stall depends only on the registered count so fetch never sees a combinational loop through decode.
   assign fifo_valid = (count_reg != '0);
   assign is_stall   = (count_reg == CW'(DEPTH));
   assign occupancy  = count_reg;

`ifdef IFID_BYPASS_EN
   assign bypass = !fifo_valid && in_valid && id_ready && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign push = in_valid && !is_stall && !flush && !bypass;
   assign pop  = fifo_valid && id_ready && !flush;

   always_comb begin
      id_valid = 1'b0;
      id_pc    = '0;
      id_instr = NOP_INSTR;
      if (fifo_valid && !flush) begin
         id_valid = 1'b1;
         id_pc    = pc_mem[rd_ptr_reg];
         id_instr = instr_mem[rd_ptr_reg];
      end else if (bypass) begin
         id_valid = 1'b1;
         id_pc    = in_pc;
         id_instr = in_instr;
      end
   end

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
         end
         if (push && !pop) begin
            count_next = count_reg + CW'(1);
         end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Entry contents are never reset or cleared; validity is tracked solely by count and pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_reg]    <= in_pc;
         instr_mem[wr_ptr_reg] <= in_instr;
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2, no bypass): reset, streaming, backpressure, flush, wrap, async reset.
module tb_if_id_queue;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic        is_stall;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic [1:0]  occupancy;

   int tests = 0;
   int fails = 0;

   if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .is_stall  (is_stall),
      .flush     (flush),
      .id_valid  (id_valid),
      .id_ready  (id_ready),
      .id_pc     (id_pc),
      .id_instr  (id_instr),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_valid"}, 32'(id_valid), 32'd0);
      chk({tag, "_pc"},    id_pc, 32'd0);
      chk({tag, "_instr"}, id_instr, NOP);
      chk({tag, "_stall"}, 32'(is_stall), 32'd0);
      chk({tag, "_occ"},   32'(occupancy), 32'd0);
   endtask

   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid = v;
      in_pc    = pc;
      in_instr = 32'hA000_0000 | pc;
   endtask

   logic [31:0] q[$];
   int          sent;
   int          recv;
   logic        m_push;
   logic        m_pop;

   initial begin
      // Reset held low with random inputs, checked before any clock edge
      reset    = 1'b0;
      in_valid = 1'($urandom);
      in_pc    = $urandom;
      in_instr = $urandom;
      flush    = 1'($urandom);
      id_ready = 1'($urandom);
      #3;
      chk_reset_vals("rst0");
      @(negedge clk);
      @(negedge clk);
      chk_reset_vals("rst1");
      drive(1'b0, 32'd0);
      flush    = 1'b0;
      id_ready = 1'b1;
      reset    = 1'b1;

      // Streaming: one word per cycle, one cycle latency
      for (int i = 0; i <= 20; i++) begin
         @(negedge clk);
         if (i > 0) begin
            $display("[TB] stream pop pc=%h instr=%h occ=%0d", id_pc, id_instr, occupancy);
            chk("stream_valid", 32'(id_valid), 32'd1);
            chk("stream_pc", id_pc, 32'(4 * (i - 1)));
            chk("stream_instr", id_instr, 32'hA000_0000 | 32'(4 * (i - 1)));
            chk("stream_stall", 32'(is_stall), 32'd0);
         end
         if (i < 20) drive(1'b1, 32'(4 * i));
         else        drive(1'b0, 32'd0);
      end
      @(negedge clk);
      chk("stream_end_occ", 32'(occupancy), 32'd0);
      chk("stream_end_valid", 32'(id_valid), 32'd0);

      // Backpressure to full, then simultaneous pop/push at full
      id_ready = 1'b0;
      drive(1'b1, 32'h00);
      @(negedge clk);
      chk("bp_occ1", 32'(occupancy), 32'd1);
      drive(1'b1, 32'h04);
      @(negedge clk);
      chk("bp_occ2", 32'(occupancy), 32'd2);
      chk("bp_stall", 32'(is_stall), 32'd1);
      chk("bp_head", id_pc, 32'h00);
      drive(1'b1, 32'h08);
      @(negedge clk);
      chk("bp_held_occ", 32'(occupancy), 32'd2);
      chk("bp_held_head", id_pc, 32'h00);
      id_ready = 1'b1;
      @(negedge clk);
      $display("[TB] bp pop pc=%h occ=%0d stall=%0d", id_pc, occupancy, is_stall);
      chk("full_pp_occ", 32'(occupancy), 32'd1);
      chk("full_pp_stall", 32'(is_stall), 32'd0);
      chk("bp_order1", id_pc, 32'h04);
      @(negedge clk);
      chk("bp_order2", id_pc, 32'h08);
      chk("bp_order2_occ", 32'(occupancy), 32'd1);
      drive(1'b0, 32'd0);
      @(negedge clk);
      chk("bp_drain_occ", 32'(occupancy), 32'd0);
      chk("bp_drain_valid", 32'(id_valid), 32'd0);

      // Flush with an incoming word
      id_ready = 1'b0;
      drive(1'b1, 32'h10);
      @(negedge clk);
      drive(1'b1, 32'h14);
      @(negedge clk);
      chk("fl_pre_occ", 32'(occupancy), 32'd2);
      drive(1'b1, 32'h18);
      flush = 1'b1;
      #1;
      chk("fl_comb_valid", 32'(id_valid), 32'd0);
      chk("fl_comb_pc", id_pc, 32'd0);
      chk("fl_comb_instr", id_instr, NOP);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, 32'd0);
      #1;
      chk("fl_occ", 32'(occupancy), 32'd0);
      chk("fl_valid", 32'(id_valid), 32'd0);
      chk("fl_stall", 32'(is_stall), 32'd0);
      drive(1'b1, 32'h20);
      @(negedge clk);
      chk("fl_after_pc", id_pc, 32'h20);
      chk("fl_after_occ", 32'(occupancy), 32'd1);
      drive(1'b0, 32'd0);
      id_ready = 1'b1;
      @(negedge clk);
      chk("fl_after_drain", 32'(occupancy), 32'd0);

      // Wrap-around: 3*DEPTH words with alternating ready against a queue model
      sent = 0;
      recv = 0;
      q.delete();
      for (int cyc = 0; cyc < 40 && recv < 3 * DEPTH; cyc++) begin
         chk("wr_occ", 32'(occupancy), 32'(q.size()));
         chk("wr_stall", 32'(is_stall), 32'(q.size() == DEPTH));
         chk("wr_valid", 32'(id_valid), 32'(q.size() != 0));
         if (q.size() != 0) chk("wr_pc", id_pc, q[0]);
         drive(sent < 3 * DEPTH, 32'h100 + 32'(4 * sent));
         id_ready = cyc[0];
         m_pop  = (q.size() != 0) && id_ready;
         m_push = in_valid && (q.size() != DEPTH);
         if (m_pop) begin
            $display("[TB] wrap pop pc=%h", q[0]);
            void'(q.pop_front());
            recv++;
         end
         if (m_push) begin
            q.push_back(in_pc);
            sent++;
         end
         @(negedge clk);
      end
      chk("wr_all_recv", 32'(recv), 32'(3 * DEPTH));

      // Asynchronous reset mid-burst, no clock edge in between
      id_ready = 1'b0;
      drive(1'b1, 32'h200);
      @(negedge clk);
      drive(1'b1, 32'h204);
      @(negedge clk);
      chk("ar_pre_occ", 32'(occupancy), 32'd2);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_vals("ar");
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
